// File: rtl/led_speed_ctrl.sv
// Key-driven LED speed selector: synchronized, debounced push buttons step a 3-bit level and its period.
// Optional macro LED_SPEED_WRAP_EN makes the level wrap at 0/7 instead of saturating.
module led_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MIN_COUNT       = 195312,
    parameter int unsigned RESET_LEVEL     = 3
) (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        key_faster_n,
    input  logic        key_slower_n,
    output logic [24:0] count_max,
    output logic [2:0]  level,
    output logic        step_pulse
);

    localparam int unsigned NKEY  = 2;
    localparam int unsigned CM_W  = 25;
    localparam int unsigned LVL_W = 3;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CM_W-1:0]  MIN_CM   = CM_W'(MIN_COUNT);
    localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(7);
    localparam logic [LVL_W-1:0] RST_LVL  = LVL_W'(RESET_LEVEL);
    localparam logic [CM_W-1:0]  RST_CM   = MIN_CM << (LVL_TOP - RST_LVL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STEP     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Reset: asserted asynchronously, released through two flops.
    logic rst_meta;
    logic rst_n;

    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Marks when the key synchronizers hold real samples rather than reset values.
    logic [1:0] warm_q;

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= 2'b00;
        end else begin
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    // Per key: bit 0 = faster, bit 1 = slower.
    logic [NKEY-1:0]            key_raw;
    logic [NKEY-1:0]            sync1_q;
    logic [NKEY-1:0]            sync2_q;
    logic [NKEY-1:0]            stable_q;
    logic [NKEY-1:0]            stable_prev_q;
    logic [NKEY-1:0]            armed_q;
    logic [NKEY-1:0][CNT_W-1:0] cnt_q;
    logic [NKEY-1:0]            press_c;

    assign key_raw = {key_slower_n, key_faster_n};

    // A key held through reset stays unarmed until it is seen released, so it cannot fire.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            armed_q       <= '0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= key_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int k = 0; k < NKEY; k++) begin
                if (sync2_q[k] == stable_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    stable_q[k] <= sync2_q[k];
                    cnt_q[k]    <= '0;
                end else begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
                if (warm_q[1] && sync2_q[k] && stable_q[k]) begin
                    armed_q[k] <= 1'b1;
                end
            end
        end
    end

    assign press_c = stable_prev_q & ~stable_q & armed_q;

    state_t            state_q;
    state_t            state_nxt;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic [CM_W-1:0]   count_max_q;
    logic [CM_W-1:0]   count_max_nxt;
    logic              step_pulse_q;
    logic              step_pulse_nxt;
    logic              up_q;
    logic              up_nxt;
    logic              limit_c;

`ifdef LED_SPEED_WRAP_EN
    assign limit_c = 1'b0;
`else
    assign limit_c = (press_c[0] && (level_q == LVL_TOP)) ||
                     (press_c[1] && (level_q == '0));
`endif

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            level_q      <= RST_LVL;
            count_max_q  <= RST_CM;
            step_pulse_q <= 1'b0;
            up_q         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            level_q      <= level_nxt;
            count_max_q  <= count_max_nxt;
            step_pulse_q <= step_pulse_nxt;
            up_q         <= up_nxt;
        end
    end

    // Next-state and output logic; 3-bit arithmetic wraps naturally when limits are disabled.
    always_comb begin
        state_nxt      = state_q;
        level_nxt      = level_q;
        count_max_nxt  = count_max_q;
        step_pulse_nxt = 1'b0;
        up_nxt         = up_q;
        case (state_q)
            IDLE: begin
                if ((press_c == 2'b01) || (press_c == 2'b10)) begin
                    up_nxt    = press_c[0];
                    state_nxt = limit_c ? WAIT_REL : STEP;
                end
            end
            STEP: begin
                level_nxt      = up_q ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
                count_max_nxt  = MIN_CM << (LVL_TOP - level_nxt);
                step_pulse_nxt = 1'b1;
                state_nxt      = WAIT_REL;
            end
            WAIT_REL: begin
                if (&stable_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign count_max  = count_max_q;
    assign level      = level_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_speed_ctrl.sv
// Randomized self-checking bench for led_speed_ctrl with a level/pulse-count reference model.
// Honours LED_SPEED_WRAP_EN for the end-of-range expectations.
module tb_led_speed_ctrl;

    localparam int unsigned DEB       = 4;
    localparam int unsigned MIN_COUNT = 195312;
    localparam int unsigned RST_LEVEL = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_faster_n = 1'b1;
    logic        key_slower_n = 1'b1;
    logic [24:0] count_max;
    logic [2:0]  level;
    logic        step_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int mlvl = RST_LEVEL;
    int mpulses = 0;
    logic prev_pulse = 1'b0;

    always #10 clk = ~clk;

    led_speed_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_COUNT      (MIN_COUNT),
        .RESET_LEVEL    (RST_LEVEL)
    ) dut (
        .CLK_50M     (clk),
        .reset       (reset_n),
        .key_faster_n(key_faster_n),
        .key_slower_n(key_slower_n),
        .count_max   (count_max),
        .level       (level),
        .step_pulse  (step_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int period(input int lv);
        return int'(MIN_COUNT) * (1 << (7 - lv));
    endfunction

    // Every strobe must be one cycle wide and carry a period consistent with its level.
    always @(negedge clk) begin
        if (reset_n) begin
            if (step_pulse) begin
                pulse_cnt++;
                check("pulse_width", 32'(prev_pulse), 32'd0);
                check("pulse_cm", 32'(count_max), 32'(period(int'(level))));
            end
            prev_pulse = step_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // Reference: one accepted press moves the level by one, limited or wrapping at the ends.
    function automatic void model_press(input bit up);
        if (up) begin
            if (mlvl == 7) begin
`ifdef LED_SPEED_WRAP_EN
                mlvl = 0;
                mpulses++;
`endif
            end else begin
                mlvl++;
                mpulses++;
            end
        end else begin
            if (mlvl == 0) begin
`ifdef LED_SPEED_WRAP_EN
                mlvl = 7;
                mpulses++;
`endif
            end else begin
                mlvl--;
                mpulses++;
            end
        end
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit f, input bit s, input int hold);
        cycles(1);
        key_faster_n = !f;
        key_slower_n = !s;
        cycles(hold);
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        cycles(16);
    endtask

    task automatic verify(input string tag);
        @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'(mlvl));
        check({tag, "_cm"}, 32'(count_max), 32'(period(mlvl)));
        check({tag, "_pulses"}, 32'(pulse_cnt), 32'(mpulses));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycles(3);
        pulse_cnt = 0;
        mpulses = 0;
        mlvl = RST_LEVEL;
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cycles(20);
        verify("reset");
        check("reset_cm_abs", 32'(count_max), 32'd3124992);

        push(1'b1, 1'b0, 10);
        model_press(1'b1);
        verify("faster");
        check("faster_cm_abs", 32'(count_max), 32'd1562496);

        push(1'b0, 1'b1, 3);
        verify("glitch");

        push(1'b1, 1'b1, 10);
        verify("both");

        push(1'b0, 1'b1, 9);
        model_press(1'b0);
        verify("slower");

        do_reset();
        cycles(10);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b0, 10);
            model_press(1'b1);
        end
        verify("five_faster");
`ifdef LED_SPEED_WRAP_EN
        check("five_lvl_abs", 32'(level), 32'd0);
        check("five_cm_abs", 32'(count_max), 32'd24999936);
        check("five_pulses_abs", 32'(pulse_cnt), 32'd5);
`else
        check("five_lvl_abs", 32'(level), 32'd7);
        check("five_cm_abs", 32'(count_max), 32'd195312);
        check("five_pulses_abs", 32'(pulse_cnt), 32'd4);
`endif

        // Reset during a debounce with the key held: nothing until released and pressed again.
        cycles(1);
        key_faster_n = 1'b0;
        cycles(3);
        do_reset();
        cycles(25);
        verify("held_reset");
        key_faster_n = 1'b1;
        cycles(16);
        verify("held_release");
        push(1'b1, 1'b0, 10);
        model_press(1'b1);
        verify("held_repress");

        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    push(1'b1, 1'b0, int'($urandom_range(8, 14)));
                    model_press(1'b1);
                end
                1, 2: begin
                    push(1'b0, 1'b1, int'($urandom_range(8, 14)));
                    model_press(1'b0);
                end
                3: push($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        int'($urandom_range(1, 3)));
                default: push(1'b1, 1'b1, int'($urandom_range(8, 14)));
            endcase
            verify($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
